// File: rtl/imm_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imm_share_arbiter
// Description : Round-robin arbiter that shares one RV64I immediate decoder
//               between decode (port 0) and branch-target precompute (port 1).
//               The winning instruction's immediate is sign-extended and held
//               in a single-entry registered output stage (valid/ready).
// Ports       : clk, rst_n (async active-low), flush
//               req0_* / req1_*  : valid, ready, 32-bit inst, tag
//               out_*            : valid, ready, imm, noimm, src, tag
//               conflict_cnt     : saturating count of both-valid cycles
// Revision    : 1.0 - initial release
// ============================================================================
module imm_share_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_W      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [31:0]           req0_inst,
  input  logic [TAG_W-1:0]      req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [31:0]           req1_inst,
  input  logic [TAG_W-1:0]      req1_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_noimm,
  output logic                  out_src,
  output logic [TAG_W-1:0]      out_tag,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam logic [6:0] c_OP_IMM    = 7'h13;
  localparam logic [6:0] c_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] c_LOAD      = 7'h03;
  localparam logic [6:0] c_JALR      = 7'h67;
  localparam logic [6:0] c_STORE     = 7'h23;
  localparam logic [6:0] c_BRANCH    = 7'h63;
  localparam logic [6:0] c_JAL       = 7'h6F;
  localparam logic [6:0] c_AUIPC     = 7'h17;
  localparam logic [6:0] c_LUI       = 7'h37;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_imm_q,   out_imm_d;
  logic                  out_noimm_q, out_noimm_d;
  logic                  out_src_q,   out_src_d;
  logic [TAG_W-1:0]      out_tag_q,   out_tag_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  last_grant_q, last_grant_d;

  logic                  w_slot_free;
  logic                  w_accept;
  logic                  w_grant1;
  logic                  w_both;
  logic [31:0]           w_inst;
  logic [TAG_W-1:0]      w_tag;
  logic [31:0]           w_imm32;
  logic                  w_noimm;
  logic [DATA_WIDTH-1:0] w_imm_ext;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on conflict the port that did
  // not win the previous accept gets the grant.
  // ---------------------------------------------------------------------------
  assign w_both      = req0_valid & req1_valid;
  assign w_slot_free = ~out_valid_q | out_ready;
  assign w_accept    = w_slot_free & ~flush & (req0_valid | req1_valid);
  assign w_grant1    = req1_valid & (~req0_valid | ~last_grant_q);

  assign req0_ready  = w_accept & ~w_grant1;
  assign req1_ready  = w_accept &  w_grant1;

  assign w_inst      = w_grant1 ? req1_inst : req0_inst;
  assign w_tag       = w_grant1 ? req1_tag  : req0_tag;

  // ---------------------------------------------------------------------------
  // Immediate decode to a 32-bit sign-extended value first; widening to
  // DATA_WIDTH is done separately so a 32-bit build needs no zero-width pad.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_imm32 = '0;
    w_noimm = 1'b0;
    case (w_inst[6:0])
      c_OP_IMM, c_OP_IMM_32, c_LOAD, c_JALR:
        w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
      c_STORE:
        w_imm32 = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      c_BRANCH:
        w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25],
                   w_inst[11:8], 1'b0};
      c_JAL:
        w_imm32 = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20],
                   w_inst[30:21], 1'b0};
      c_AUIPC, c_LUI:
        w_imm32 = {w_inst[31:12], 12'h000};
      default:
        w_noimm = 1'b1;
    endcase
  end

  generate
    if (DATA_WIDTH > 32) begin : g_wide
      assign w_imm_ext = {{(DATA_WIDTH-32){w_imm32[31]}}, w_imm32};
    end else begin : g_narrow
      assign w_imm_ext = w_imm32[DATA_WIDTH-1:0];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output stage next-state. Flush only clears valid; the stale payload is
  // harmless because nothing qualifies it without out_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_noimm_d  = out_noimm_q;
    out_src_d    = out_src_q;
    out_tag_d    = out_tag_q;
    last_grant_d = last_grant_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_accept) begin
      out_valid_d  = 1'b1;
      out_imm_d    = w_imm_ext;
      out_noimm_d  = w_noimm;
      out_src_d    = w_grant1;
      out_tag_d    = w_tag;
      last_grant_d = w_grant1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Conflict counter ignores slot/flush state and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (w_both && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // last_grant resets to 1 so port 0 takes the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_noimm_q  <= 1'b0;
      out_src_q    <= 1'b0;
      out_tag_q    <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_noimm_q  <= out_noimm_d;
      out_src_q    <= out_src_d;
      out_tag_q    <= out_tag_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_imm      = out_imm_q;
  assign out_noimm    = out_noimm_q;
  assign out_src      = out_src_q;
  assign out_tag      = out_tag_q;
  assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire
